// File: rtl/writeback_multi_stage_if.sv
// rtl/writeback_multi_stage_if.sv - enqueue lanes and register-file drain ports of the writeback stage
// Ports: stall_v_i, in_* lane bundle (LANES_P wide, lane 0 oldest), in_ready_o,
//        rd_o/rd_data_o/rd_w_v_o write ports (WPORTS_P wide), br_v_o/btaken_o/br_tgt_o redirect,
//        retire_cnt_o. The master modport drives the lanes; the slave modport is the writeback stage.
interface writeback_multi_stage_if #(
    parameter int LANES_P          = 2,
    parameter int WPORTS_P         = 2,
    parameter int WORD_WIDTH_P     = 32,
    parameter int REG_ADDR_WIDTH_P = 5
);
    localparam int RC_W = $clog2(WPORTS_P + 1);

    logic                                   stall_v_i;
    logic [LANES_P-1:0]                     in_v_i;
    logic                                   in_ready_o;
    logic [LANES_P*WORD_WIDTH_P-1:0]        in_pc_i;
    logic [LANES_P*REG_ADDR_WIDTH_P-1:0]    in_rd_i;
    logic [LANES_P-1:0]                     in_rd_w_v_i;
    logic [LANES_P*2-1:0]                   in_rdmux_sel_i;
    logic [LANES_P*WORD_WIDTH_P-1:0]        in_alu_result_i;
    logic [LANES_P*WORD_WIDTH_P-1:0]        in_ld_result_i;
    logic [LANES_P*3-1:0]                   in_funct3_i;
    logic [LANES_P-1:0]                     in_br_v_i;
    logic [LANES_P-1:0]                     in_bru_result_i;
    logic [LANES_P-1:0]                     in_jmp_v_i;

    logic [WPORTS_P*REG_ADDR_WIDTH_P-1:0]   rd_o;
    logic [WPORTS_P*WORD_WIDTH_P-1:0]       rd_data_o;
    logic [WPORTS_P-1:0]                    rd_w_v_o;
    logic                                   br_v_o;
    logic                                   btaken_o;
    logic [WORD_WIDTH_P-1:0]                br_tgt_o;
    logic [RC_W-1:0]                        retire_cnt_o;

    modport master (
        output stall_v_i, in_v_i, in_pc_i, in_rd_i, in_rd_w_v_i, in_rdmux_sel_i,
               in_alu_result_i, in_ld_result_i, in_funct3_i, in_br_v_i,
               in_bru_result_i, in_jmp_v_i,
        input  in_ready_o, rd_o, rd_data_o, rd_w_v_o, br_v_o, btaken_o, br_tgt_o,
               retire_cnt_o
    );

    modport slave (
        input  stall_v_i, in_v_i, in_pc_i, in_rd_i, in_rd_w_v_i, in_rdmux_sel_i,
               in_alu_result_i, in_ld_result_i, in_funct3_i, in_br_v_i,
               in_bru_result_i, in_jmp_v_i,
        output in_ready_o, rd_o, rd_data_o, rd_w_v_o, br_v_o, btaken_o, br_tgt_o,
               retire_cnt_o
    );
endinterface

// File: rtl/writeback_multi_stage.sv
// rtl/writeback_multi_stage.sv - multi-lane in-order retire buffer with rd data select and redirect flush
// Ports: clk_i, rst_i (sync active-high), wb (writeback_multi_stage_if.slave: lanes in, write ports out).
// Optional: WRITEBACK_PERF_CTR_EN adds perf_retired_o[63:0] and perf_redirect_o[31:0] saturating counters.
module writeback_multi_stage #(
    parameter int LANES_P          = 2,
    parameter int WPORTS_P         = 2,
    parameter int DEPTH_P          = 8,
    parameter int WORD_WIDTH_P     = 32,
    parameter int REG_ADDR_WIDTH_P = 5
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    writeback_multi_stage_if.slave       wb
`ifdef WRITEBACK_PERF_CTR_EN
    ,
    output logic [63:0]                  perf_retired_o,
    output logic [31:0]                  perf_redirect_o
`endif
);
    localparam int W     = WORD_WIDTH_P;
    localparam int RA    = REG_ADDR_WIDTH_P;
    localparam int PTR_W = $clog2(DEPTH_P);
    localparam int CNT_W = PTR_W + 1;
    localparam int RC_W  = $clog2(WPORTS_P + 1);

    // Buffer stores final rd data plus precomputed redirect info per entry.
    logic [RA-1:0]    rd_q    [DEPTH_P];
    logic [W-1:0]     data_q  [DEPTH_P];
    logic             wv_q    [DEPTH_P];
    logic             isbr_q  [DEPTH_P];
    logic             taken_q [DEPTH_P];
    logic [W-1:0]     tgt_q   [DEPTH_P];

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             enq_fire;
    logic [CNT_W-1:0] enq_n;
    logic [W-1:0]     lane_data [LANES_P];
    logic             in_v_contig;

    logic [WPORTS_P*RA-1:0] rd_c;
    logic [WPORTS_P*W-1:0]  rd_data_c;
    logic [WPORTS_P-1:0]    rd_w_v_c;
    logic                   br_v_c, btaken_c, br_seen, done;
    logic [W-1:0]           br_tgt_c;
    logic [RC_W-1:0]        retire_c;
    logic [PTR_W-1:0]       idx;

    function automatic logic [W-1:0] fmt_load(input logic [W-1:0] raw, input logic [2:0] f3);
        case (f3)
            3'd0:    return {{(W-8){raw[7]}}, raw[7:0]};
            3'd1:    return {{(W-16){raw[15]}}, raw[15:0]};
            3'd4:    return {{(W-8){1'b0}}, raw[7:0]};
            3'd5:    return {{(W-16){1'b0}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    assign wb.in_ready_o = (count_q <= CNT_W'(DEPTH_P - LANES_P));
    assign enq_fire      = wb.in_ready_o && wb.in_v_i[0];
    assign in_v_contig   = (((wb.in_v_i + LANES_P'(1)) & wb.in_v_i) == '0);

    // Per-lane rd data selection and enqueue width.
    always_comb begin
        enq_n = '0;
        for (int l = 0; l < LANES_P; l++) begin
            case (wb.in_rdmux_sel_i[l*2 +: 2])
                2'd1:    lane_data[l] = fmt_load(wb.in_ld_result_i[l*W +: W], wb.in_funct3_i[l*3 +: 3]);
                2'd2:    lane_data[l] = wb.in_pc_i[l*W +: W] + W'(4);
                default: lane_data[l] = wb.in_alu_result_i[l*W +: W];
            endcase
            if (wb.in_v_i[l]) enq_n = enq_n + CNT_W'(1);
        end
    end

    // Drain: walk the oldest entries; a taken redirect ends the group after its own write.
    always_comb begin
        rd_c      = '0;
        rd_data_c = '0;
        rd_w_v_c  = '0;
        br_v_c    = 1'b0;
        btaken_c  = 1'b0;
        br_tgt_c  = '0;
        br_seen   = 1'b0;
        done      = 1'b0;
        retire_c  = '0;
        idx       = '0;
        for (int k = 0; k < WPORTS_P; k++) begin
            idx = head_q + PTR_W'(k);
            if (!wb.stall_v_i && !done && (CNT_W'(k) < count_q)) begin
                rd_c[k*RA +: RA]    = rd_q[idx];
                rd_data_c[k*W +: W] = data_q[idx];
                rd_w_v_c[k]         = wv_q[idx] && (rd_q[idx] != '0);
                retire_c            = retire_c + RC_W'(1);
                if (!br_seen && isbr_q[idx]) begin
                    br_seen  = 1'b1;
                    br_v_c   = 1'b1;
                    br_tgt_c = tgt_q[idx];
                    btaken_c = taken_q[idx];
                    done     = taken_q[idx];
                end
            end
        end
    end

    assign wb.rd_o         = rd_c;
    assign wb.rd_data_o    = rd_data_c;
    assign wb.rd_w_v_o     = rd_w_v_c;
    assign wb.br_v_o       = br_v_c;
    assign wb.btaken_o     = btaken_c;
    assign wb.br_tgt_o     = br_tgt_c;
    assign wb.retire_cnt_o = retire_c;

    // A taken redirect flushes everything younger, including this cycle's enqueue.
    always_comb begin
        head_d  = head_q + PTR_W'(retire_c);
        tail_d  = tail_q;
        count_d = count_q - CNT_W'(retire_c);
        if (btaken_c) begin
            head_d  = tail_q;
            count_d = '0;
        end else if (enq_fire) begin
            tail_d  = tail_q + PTR_W'(enq_n);
            count_d = count_q + enq_n - CNT_W'(retire_c);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            assert (in_v_contig);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && enq_fire && !btaken_c) begin
            for (int l = 0; l < LANES_P; l++) begin
                if (wb.in_v_i[l]) begin
                    rd_q   [tail_q + PTR_W'(l)] <= wb.in_rd_i[l*RA +: RA];
                    data_q [tail_q + PTR_W'(l)] <= lane_data[l];
                    wv_q   [tail_q + PTR_W'(l)] <= wb.in_rd_w_v_i[l];
                    isbr_q [tail_q + PTR_W'(l)] <= wb.in_br_v_i[l] | wb.in_jmp_v_i[l];
                    taken_q[tail_q + PTR_W'(l)] <= wb.in_jmp_v_i[l] | (wb.in_br_v_i[l] & wb.in_bru_result_i[l]);
                    tgt_q  [tail_q + PTR_W'(l)] <= wb.in_alu_result_i[l*W +: W];
                end
            end
        end
    end

`ifdef WRITEBACK_PERF_CTR_EN
    logic [63:0] perf_ret_q;
    logic [31:0] perf_red_q;
    logic [64:0] ret_sum;

    assign ret_sum = {1'b0, perf_ret_q} + 65'(retire_c);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_ret_q <= '0;
            perf_red_q <= '0;
        end else if (!wb.stall_v_i) begin
            perf_ret_q <= ret_sum[64] ? '1 : ret_sum[63:0];
            if (btaken_c && perf_red_q != '1) perf_red_q <= perf_red_q + 32'd1;
        end
    end

    assign perf_retired_o  = perf_ret_q;
    assign perf_redirect_o = perf_red_q;
`endif
endmodule

// File: tb/tb_writeback_multi_stage.sv
// tb/tb_writeback_multi_stage.sv - scoreboard bench for writeback_multi_stage
module tb_writeback_multi_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    writeback_multi_stage_if #(.LANES_P(2), .WPORTS_P(2), .WORD_WIDTH_P(32), .REG_ADDR_WIDTH_P(5)) wb ();

`ifdef WRITEBACK_PERF_CTR_EN
    logic [63:0] perf_ret;
    logic [31:0] perf_red;
`endif

    writeback_multi_stage #(.LANES_P(2), .WPORTS_P(2), .DEPTH_P(8), .WORD_WIDTH_P(32), .REG_ADDR_WIDTH_P(5)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .wb    (wb)
`ifdef WRITEBACK_PERF_CTR_EN
        ,
        .perf_retired_o  (perf_ret),
        .perf_redirect_o (perf_red)
`endif
    );

    typedef struct {
        logic [1:0]  wv;
        logic [63:0] data;
        logic [1:0]  rc;
        logic        brv;
        logic        bt;
        logic [31:0] tgt;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [1:0] wv, input logic [31:0] d1, input logic [31:0] d0,
                            input logic [1:0] rc, input logic brv, input logic bt, input logic [31:0] tgt);
        exp_t e;
        e.wv = wv; e.data = {d1, d0}; e.rc = rc; e.brv = brv; e.bt = bt; e.tgt = tgt;
        exp_q.push_back(e);
    endtask

    // Monitor: pops an expectation whenever the DUT retires something.
    always @(negedge clk) begin
        if (!rst) begin
            if (wb.stall_v_i) begin
                chk("stall_quiet", {60'd0, wb.retire_cnt_o, wb.rd_w_v_o}, 64'd0);
            end else if (wb.retire_cnt_o != 2'd0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_retire", 64'(wb.retire_cnt_o), 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("retire_cnt", 64'(wb.retire_cnt_o), 64'(e.rc));
                    chk("rd_w_v", 64'(wb.rd_w_v_o), 64'(e.wv));
                    for (int k = 0; k < 2; k++)
                        if (e.wv[k]) chk("rd_data", 64'(wb.rd_data_o[k*32 +: 32]), 64'(e.data[k*32 +: 32]));
                    chk("br_v", 64'(wb.br_v_o), 64'(e.brv));
                    chk("btaken", 64'(wb.btaken_o), 64'(e.bt));
                    if (e.brv) chk("br_tgt", 64'(wb.br_tgt_o), 64'(e.tgt));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_lanes();
        wb.in_v_i = '0; wb.in_pc_i = '0; wb.in_rd_i = '0; wb.in_rd_w_v_i = '0;
        wb.in_rdmux_sel_i = '0; wb.in_alu_result_i = '0; wb.in_ld_result_i = '0;
        wb.in_funct3_i = '0; wb.in_br_v_i = '0; wb.in_bru_result_i = '0; wb.in_jmp_v_i = '0;
    endtask

    task automatic set_lane(input int l, input logic [31:0] pc, input logic [4:0] rd, input logic wv,
                            input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] ld,
                            input logic [2:0] f3, input logic br, input logic bru, input logic jmp);
        wb.in_v_i[l] = 1'b1;
        wb.in_pc_i[l*32 +: 32] = pc;
        wb.in_rd_i[l*5 +: 5] = rd;
        wb.in_rd_w_v_i[l] = wv;
        wb.in_rdmux_sel_i[l*2 +: 2] = sel;
        wb.in_alu_result_i[l*32 +: 32] = alu;
        wb.in_ld_result_i[l*32 +: 32] = ld;
        wb.in_funct3_i[l*3 +: 3] = f3;
        wb.in_br_v_i[l] = br;
        wb.in_bru_result_i[l] = bru;
        wb.in_jmp_v_i[l] = jmp;
    endtask

    initial begin
        wb.stall_v_i = 1'b0;
        clear_lanes();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("reset_in_ready", 64'(wb.in_ready_o), 64'd1);
        chk("reset_rd_w_v", 64'(wb.rd_w_v_o), 64'd0);
        chk("reset_retire_cnt", 64'(wb.retire_cnt_o), 64'd0);
        chk("reset_br_v", 64'({wb.br_v_o, wb.btaken_o}), 64'd0);

        // Two ALU lanes.
        set_lane(0, 32'h0, 5'd1, 1'b1, 2'd0, 32'h10, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        set_lane(1, 32'h4, 5'd2, 1'b1, 2'd0, 32'h20, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        push_exp(2'b11, 32'h20, 32'h10, 2'd2, 1'b0, 1'b0, 32'h0);
        tick();
        clear_lanes();
        tick();
        tick();

        // Loads: LB sign-extend, LHU zero-extend.
        set_lane(0, 32'h0, 5'd3, 1'b1, 2'd1, 32'h0, 32'h000000F0, 3'd0, 1'b0, 1'b0, 1'b0);
        set_lane(1, 32'h0, 5'd4, 1'b1, 2'd1, 32'h0, 32'h8001F234, 3'd5, 1'b0, 1'b0, 1'b0);
        push_exp(2'b11, 32'h0000F234, 32'hFFFFFFF0, 2'd2, 1'b0, 1'b0, 32'h0);
        tick();
        clear_lanes();
        tick();
        tick();

        // Stall while filling: 4 enqueues of 2 reach depth 8.
        wb.stall_v_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("fill_in_ready", 64'(wb.in_ready_o), 64'd1);
            set_lane(0, 32'h0, 5'(10 + 2*i), 1'b1, 2'd0, 32'((10 + 2*i) * 16), 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
            set_lane(1, 32'h0, 5'(11 + 2*i), 1'b1, 2'd0, 32'((11 + 2*i) * 16), 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
            push_exp(2'b11, 32'((11 + 2*i) * 16), 32'((10 + 2*i) * 16), 2'd2, 1'b0, 1'b0, 32'h0);
            tick();
        end
        clear_lanes();
        chk("full_in_ready", 64'(wb.in_ready_o), 64'd0);
        tick();
        chk("full_hold_in_ready", 64'(wb.in_ready_o), 64'd0);
        wb.stall_v_i = 1'b0;
        repeat (4) tick();
        chk("drained_in_ready", 64'(wb.in_ready_o), 64'd1);
        chk("drained_retire_cnt", 64'(wb.retire_cnt_o), 64'd0);

        // JAL in lane 0 flushes lane 1 and a same-cycle enqueue.
        set_lane(0, 32'h100, 5'd1, 1'b1, 2'd2, 32'h200, 32'h0, 3'd0, 1'b0, 1'b0, 1'b1);
        set_lane(1, 32'h104, 5'd3, 1'b1, 2'd0, 32'h33, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        push_exp(2'b01, 32'h0, 32'h104, 2'd1, 1'b1, 1'b1, 32'h200);
        tick();
        clear_lanes();
        set_lane(0, 32'h0, 5'd7, 1'b1, 2'd0, 32'h77, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        clear_lanes();
        chk("flush_retire_cnt", 64'(wb.retire_cnt_o), 64'd0);
        chk("flush_in_ready", 64'(wb.in_ready_o), 64'd1);
        tick();
        chk("flush_discard_enq", 64'(wb.retire_cnt_o), 64'd0);

        // Not-taken branch then ALU rd=5, both retire together.
        set_lane(0, 32'h300, 5'd0, 1'b0, 2'd0, 32'h300, 32'h0, 3'd0, 1'b1, 1'b0, 1'b0);
        set_lane(1, 32'h304, 5'd5, 1'b1, 2'd0, 32'h55, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        push_exp(2'b10, 32'h55, 32'h0, 2'd2, 1'b1, 1'b0, 32'h300);
        tick();
        clear_lanes();
        tick();
        tick();

        // Write to x0 retires without a write.
        set_lane(0, 32'h0, 5'd0, 1'b1, 2'd0, 32'hDEAD, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        push_exp(2'b00, 32'h0, 32'h0, 2'd1, 1'b0, 1'b0, 32'h0);
        tick();
        clear_lanes();
        tick();
        tick();

        // Reset with 3 entries buffered.
        wb.stall_v_i = 1'b1;
        set_lane(0, 32'h0, 5'd20, 1'b1, 2'd0, 32'h1, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        set_lane(1, 32'h0, 5'd21, 1'b1, 2'd0, 32'h2, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        clear_lanes();
        set_lane(0, 32'h0, 5'd22, 1'b1, 2'd0, 32'h3, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        clear_lanes();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wb.stall_v_i = 1'b0;
        chk("rst_mid_rd_w_v", 64'(wb.rd_w_v_o), 64'd0);
        chk("rst_mid_retire_cnt", 64'(wb.retire_cnt_o), 64'd0);
        chk("rst_mid_in_ready", 64'(wb.in_ready_o), 64'd1);
        tick();
        chk("rst_mid_later_retire", 64'(wb.retire_cnt_o), 64'd0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/writeback_multi_stage.md
Name: writeback_multi_stage

Overview:
- Parametrised multi-lane writeback stage sitting between the memory stage(s) and the register file / fetch redirect.
- Accepts up to LANES_P results per cycle in program order into an in-order retire buffer.
- Drains up to WPORTS_P oldest entries per cycle onto register-file write ports.
- Selects rd data per entry (ALU, sign/zero-extended load, pc+4) and resolves branch/jump redirects with younger-entry flush.

Parameters:
- LANES_P, 2: input lanes per cycle; lane 0 is oldest.
- WPORTS_P, 2: register-file write ports drained per cycle.
- DEPTH_P, 8: retire-buffer entries; power of two, at least max(LANES_P, WPORTS_P).
- WORD_WIDTH_P, 32: data/pc width.
- REG_ADDR_WIDTH_P, 5: register index width.

Ports:
- clk_i, in, 1: clock.
- rst_i, in, 1: synchronous active-high reset.
- stall_v_i, in, 1: freeze draining; enqueue still allowed.
- in_v_i, in, LANES_P: lane valid; must be contiguous from lane 0.
- in_ready_o, out, 1: free entries >= LANES_P.
- in_pc_i, in, LANES_P*WORD_WIDTH_P: per-lane pc.
- in_rd_i, in, LANES_P*REG_ADDR_WIDTH_P: per-lane destination register.
- in_rd_w_v_i, in, LANES_P: per-lane register write enable.
- in_rdmux_sel_i, in, LANES_P*2: 0 alu, 1 load, 2 pc+4, 3 reserved (treated as alu).
- in_alu_result_i, in, LANES_P*WORD_WIDTH_P: per-lane ALU result; also branch/jump target.
- in_ld_result_i, in, LANES_P*WORD_WIDTH_P: raw load word, already shifted to bit 0.
- in_funct3_i, in, LANES_P*3: load size/sign.
- in_br_v_i, in, LANES_P: entry is a conditional branch.
- in_bru_result_i, in, LANES_P: branch condition true.
- in_jmp_v_i, in, LANES_P: entry is an unconditional jump.
- rd_o, out, WPORTS_P*REG_ADDR_WIDTH_P: write-port register index.
- rd_data_o, out, WPORTS_P*WORD_WIDTH_P: write-port data.
- rd_w_v_o, out, WPORTS_P: write-port enable.
- br_v_o, out, 1: a branch or jump retired this cycle.
- btaken_o, out, 1: redirect taken.
- br_tgt_o, out, WORD_WIDTH_P: redirect target.
- retire_cnt_o, out, $clog2(WPORTS_P+1): entries retired this cycle.

Behaviour:
- Reset: head, tail and count are 0. All outputs are 0 except in_ready_o, which is 1 after reset. Reset mid-operation discards all buffered entries with no writes.
- Enqueue: an enqueue fires when in_ready_o && in_v_i[0]. All set lanes are written at tail, tail+1, ..., wrapping mod DEPTH_P. Non-contiguous in_v_i is illegal (assertion).
- Data selection happens at enqueue, so the buffer stores final rd data.
  - rdmux_sel 2 stores pc+4.
  - rdmux_sel 1 formats the load by funct3: 0 LB sign-extends [7:0]; 1 LH sign-extends [15:0]; 2 LW is the full word; 4 LBU and 5 LHU zero-extend; other codes pass the raw word through.
- Latency: an entry enqueued in cycle t is drained no earlier than t+1. All drain outputs are registered-state driven.
- Drain: when !stall_v_i, n = min(count, WPORTS_P) oldest entries are presented. Port k carries entry head+k.
  - rd_w_v_o[k] = rd_w_v && rd != 0; writes to x0 are suppressed but the entry still retires.
  - When stalled, rd_w_v_o, br_v_o and btaken_o are 0 and retire_cnt_o is 0.
- Redirect:
  - The first drained entry j with br_v or jmp_v sets br_v_o=1 and br_tgt_o=its alu_result.
  - btaken_o = jmp_v | (br_v & bru_result).
  - If btaken_o, entries after j in the same cycle are not written, the buffer is flushed (head=tail, count=0) at the clock edge, and any same-cycle enqueue is discarded. Entry j's own rd write (JAL/JALR link) is performed.
  - retire_cnt_o = j+1 on a taken redirect, else n.
- Not-taken branch: retires normally, and draining continues past it in the same cycle.
- Simultaneous enqueue and drain: count_next = count + enq - retired. in_ready_o uses the current count only, with no same-cycle credit.
- Full: count > DEPTH_P-LANES_P drops in_ready_o. Empty: count 0 gives all write enables 0.

Optional Feature:
- Macro: WRITEBACK_PERF_CTR_EN.
- Defined: adds output perf_retired_o (64 bits) and perf_redirect_o (32 bits).
  - perf_retired_o accumulates retire_cnt_o each cycle.
  - perf_redirect_o increments on each btaken_o.
  - Both reset to 0, saturate at all-ones, and ignore stall cycles.
- Undefined: no counters and no such ports.

Test Plan:
- Reset, then 2 lanes enqueue (rd=1 alu=0x10, rd=2 alu=0x20) -> next cycle rd_w_v_o=2'b11, rd_data_o={0x20,0x10}, retire_cnt_o=2.
- Load with funct3=0 and ld=0x000000F0 -> rd_data=0xFFFFFFF0. With funct3=5 and ld=0x8001F234 -> 0x0000F234.
- stall_v_i held 4 cycles while enqueuing 2 per cycle with DEPTH_P=8:
  - in_ready_o drops once count reaches 8 (after 4 enqueues); no writes occur.
  - After release, the buffer drains 2/cycle in order over 4 cycles.
- Lane0 JAL (rd=1, pc=0x100, tgt=0x200) plus lane1 ALU rd=3:
  - Drain cycle gives rd_w_v_o=2'b01 with data 0x104, br_v_o=1, btaken_o=1, br_tgt_o=0x200.
  - Lane1 is never written, and count is 0 next cycle.
- Not-taken branch (br_v=1, bru=0) followed by an ALU rd=5 -> both retire the same cycle, btaken_o=0, rd 5 written.
- rd=0 with rd_w_v=1 -> rd_w_v_o=0, retire_cnt_o=1. Assert rst_i with 3 entries buffered -> no writes next cycle, in_ready_o=1.
